bitmap_mem_sequencer: RTL and testbench

- Multi-cycle sequencer for the bitmap load/store instructions (LDB/STB). It moves one BM_WORDS-word bitmap between the bitmap datapath and the single-port 16-bit data memory, one word per cycle, and stalls the pipeline meanwhile.
- It also arbitrates that memory port with the audio note-fetch requester, which issues single-word reads.
- Sits between the decode/execute stage (start pulse derived from the LDB/STB decode with DMemEn) and the data memory.

---
 rtl/bitmap_mem_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_bitmap_mem_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bitmap_mem_sequencer
// Purpose  : Multi-cycle sequencer for bitmap load/store (LDB/STB). Moves one
//            BM_WORDS-word bitmap between the bitmap datapath and the
//            single-port data memory, one word per cycle, stalling the
//            pipeline meanwhile. Also arbitrates the memory port with the
//            audio note-fetch requester (single-word reads).
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            cpu_start/store/addr/wbm  - bitmap request from decode
//            cpu_stall, cpu_done       - pipeline stall / completion pulse
//            cpu_rbm                   - loaded bitmap (held until next load)
//            aud_req/addr              - audio read request (level)
//            aud_gnt/rvalid/rdata      - audio grant / read data return
//            mem_en/we/addr/wdata      - data memory access
//            mem_rdata                 - memory read data (1-cycle latency)
// Options  : BMSEQ_FAIR_ARB_EN - alternate audio/CPU inside a burst instead of
//            giving the CPU absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module bitmap_mem_sequencer #(
  parameter int BM_WORDS = 8,
  parameter int DW       = 16,
  parameter int AW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_start,
  input  logic                   cpu_store,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [BM_WORDS*DW-1:0] cpu_wbm,
  output logic                   cpu_stall,
  output logic                   cpu_done,
  output logic [BM_WORDS*DW-1:0] cpu_rbm,
  input  logic                   aud_req,
  input  logic [AW-1:0]          aud_addr,
  output logic                   aud_gnt,
  output logic                   aud_rvalid,
  output logic [DW-1:0]          aud_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata
);

  localparam int BW = (BM_WORDS > 1) ? $clog2(BM_WORDS) : 1;
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(BM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    store_q, store_d;
  logic [AW-1:0]           base_q, base_d;
  logic [BM_WORDS*DW-1:0]  wbm_q, wbm_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    flag_q, flag_d;        // audio took the previous slot
  logic                    done_q, done_d;
  logic [BM_WORDS*DW-1:0]  rbm_q, rbm_d;
  logic                    aud_rvalid_q, aud_rvalid_d;
  logic                    rd_pend_q, rd_pend_d;  // CPU read issued last cycle
  logic [BW-1:0]           rd_idx_q, rd_idx_d;    // which bitmap word it was
  logic                    aud_sel;

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    base_d       = base_q;
    wbm_d        = wbm_q;
    beat_d       = beat_q;
    flag_d       = flag_q;
    done_d       = 1'b0;
    rbm_d        = rbm_q;
    rd_pend_d    = 1'b0;
    rd_idx_d     = rd_idx_q;
    aud_sel      = 1'b0;
    aud_gnt      = 1'b0;
    cpu_stall    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = aud_addr;
    mem_wdata    = '0;

    // A CPU read returns one cycle later, whatever owns the port now.
    if (rd_pend_q) begin
      rbm_d[rd_idx_q*DW +: DW] = mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        aud_gnt = aud_req;
        if (cpu_start) begin
          cpu_stall = 1'b1;
          store_d   = cpu_store;
          base_d    = cpu_addr;
          wbm_d     = cpu_wbm;
          beat_d    = '0;
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        cpu_stall = 1'b1;
`ifdef BMSEQ_FAIR_ARB_EN
        aud_sel = aud_req && !flag_q;
`endif
        if (aud_sel) begin
          aud_gnt = 1'b1;
          flag_d  = 1'b1;
        end else begin
          flag_d    = 1'b0;
          mem_en    = 1'b1;
          mem_we    = store_q;
          mem_addr  = base_q + AW'(beat_q);   // wraps silently at 2^AW
          mem_wdata = wbm_q[beat_q*DW +: DW];
          rd_pend_d = !store_q;
          rd_idx_d  = beat_q;
          beat_d    = beat_q + BW'(1);
          if (beat_q == C_LAST_BEAT) begin
            // Loads need one extra cycle to capture the final read word.
            state_d = store_q ? S_DONE : S_DRAIN;
            done_d  = store_q;
          end
        end
      end
      S_DRAIN: begin
        cpu_stall = 1'b1;
        aud_gnt   = aud_req;
        state_d   = S_DONE;
        done_d    = 1'b1;
      end
      S_DONE: begin
        aud_gnt = aud_req;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (aud_gnt) begin
      mem_en   = 1'b1;
      mem_we   = 1'b0;
      mem_addr = aud_addr;
    end
    aud_rvalid_d = aud_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      base_q       <= '0;
      wbm_q        <= '0;
      beat_q       <= '0;
      flag_q       <= 1'b0;
      done_q       <= 1'b0;
      rbm_q        <= '0;
      aud_rvalid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      base_q       <= base_d;
      wbm_q        <= wbm_d;
      beat_q       <= beat_d;
      flag_q       <= flag_d;
      done_q       <= done_d;
      rbm_q        <= rbm_d;
      aud_rvalid_q <= aud_rvalid_d;
      rd_pend_q    <= rd_pend_d;
      rd_idx_q     <= rd_idx_d;
    end
  end

  assign cpu_done   = done_q;
  assign cpu_rbm    = rbm_q;
  assign aud_rvalid = aud_rvalid_q;
  assign aud_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bitmap_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitmap_mem_sequencer
// Purpose  : Scoreboard bench for bitmap_mem_sequencer. Stimulus pushes the
//            expected memory beats, completion and audio data into queues; a
//            negedge monitor pops and compares what the DUT presents.
// Options  : honours BMSEQ_FAIR_ARB_EN for the expected latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitmap_mem_sequencer;

  localparam int N   = 8;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int BMW = N * DW;
`ifdef BMSEQ_FAIR_ARB_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cpu_start = 1'b0, cpu_store = 1'b0;
  logic [AW-1:0]  cpu_addr = '0;
  logic [BMW-1:0] cpu_wbm = '0;
  logic           cpu_stall, cpu_done;
  logic [BMW-1:0] cpu_rbm;
  logic           aud_req = 1'b0;
  logic [AW-1:0]  aud_addr = 16'hC000;
  logic           aud_gnt, aud_rvalid;
  logic [DW-1:0]  aud_rdata;
  logic           mem_en, mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata = '0;

  bitmap_mem_sequencer #(.BM_WORDS(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_start(cpu_start), .cpu_store(cpu_store), .cpu_addr(cpu_addr),
    .cpu_wbm(cpu_wbm), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .cpu_rbm(cpu_rbm), .aud_req(aud_req), .aud_addr(aud_addr),
    .aud_gnt(aud_gnt), .aud_rvalid(aud_rvalid), .aud_rdata(aud_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory the DUT talks to, and the model's own copy of what it should hold.
  logic [DW-1:0] tbmem [0:65535];
  logic [DW-1:0] refm  [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata       <= tbmem[mem_addr];
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    bit             store;
    logic [AW-1:0]  base;
    int             start;
    int             lat_lo;
    int             lat_hi;
    logic [BMW-1:0] rbm;
  } op_t;
  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
  } acc_t;

  op_t           op_q[$];
  acc_t          acc_q[$];
  logic [DW-1:0] aud_q[$];
  logic [BMW-1:0] last_rbm = '0;
  int            aud_mode = 0;   // 0 off, 1 held high, 2 random
  int            n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int            stall_cnt = 0;
  bit            prev_gnt = 0;
  op_t           mo;
  acc_t          ma;
  logic [DW-1:0] md;
  logic [AW-1:0] ma16;
  int            lat;

  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
      prev_gnt  = 0;
    end else begin
      if (cpu_stall) stall_cnt++;

      if (aud_rvalid || prev_gnt) begin
        chk("rvalid_timing", aud_rvalid, prev_gnt);
        if (aud_rvalid) begin
          if (aud_q.size() == 0) chk("aud_unexpected", 1, 0);
          else begin
            md = aud_q.pop_front();
            chk("aud_rdata", aud_rdata, md);
          end
        end
      end
      prev_gnt = aud_gnt;

      if (aud_gnt) begin
        chk("aud_mem_en", mem_en, 1);
        chk("aud_mem_we", mem_we, 0);
        chk("aud_mem_addr", mem_addr, aud_addr);
        aud_q.push_back(refm[aud_addr]);
      end else if (mem_en) begin
        if (acc_q.size() == 0) chk("unexpected_access", 1, 0);
        else begin
          ma = acc_q.pop_front();
          chk("beat_addr", mem_addr, ma.addr);
          chk("beat_we", mem_we, ma.we);
          if (ma.we) chk("beat_wdata", mem_wdata, ma.wdata);
        end
      end

      if (cpu_done) begin
        chk("stall_at_done", cpu_stall, 0);
        if (op_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mo  = op_q.pop_front();
          lat = cyc_n - mo.start;
          if (mo.lat_lo == mo.lat_hi) chk("latency", lat, mo.lat_lo);
          else chk("latency_in_range", (lat >= mo.lat_lo && lat <= mo.lat_hi), 1);
          chk("stall_cycles", stall_cnt, lat);
          chk(mo.store ? "rbm_held" : "rbm_load", cpu_rbm, mo.rbm);
          chk("beats_left", acc_q.size(), 0);
          if (mo.store) begin
            for (int i = 0; i < N; i++) begin
              ma16 = mo.base + 16'(i);
              chk("mem_content", tbmem[ma16], refm[ma16]);
            end
          end
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- audio requester ----------------
  bit g;
  initial begin
    forever begin
      @(negedge clk);
      g = aud_gnt;
      @(posedge clk);
      #1;
      if (aud_mode == 0) aud_req = 1'b0;
      else if (g || !aud_req) begin
        aud_req  = (aud_mode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
        aud_addr = 16'hC000 + 16'($urandom_range(0, 255));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit st, input logic [AW-1:0] base, input logic [BMW-1:0] wbm);
    op_t  o;
    acc_t a;
    int   ld;
    logic [AW-1:0] ad;
    ld       = st ? 0 : 1;
    o.store  = st;
    o.base   = base;
    o.start  = cyc_n;
    o.lat_lo = N + 1 + ld;
    o.lat_hi = N + 1 + ld;
    if (FAIR && aud_mode == 1) begin
      o.lat_lo = 2 * N + 1 + ld;
      o.lat_hi = 2 * N + 1 + ld;
    end else if (FAIR && aud_mode == 2) begin
      o.lat_hi = 2 * N + 1 + ld;
    end
    o.rbm = '0;
    for (int i = 0; i < N; i++) begin
      ad      = base + 16'(i);
      a.addr  = ad;
      a.we    = st;
      a.wdata = wbm[i*DW +: DW];
      acc_q.push_back(a);
      if (st) refm[ad] = wbm[i*DW +: DW];
      else    o.rbm[i*DW +: DW] = refm[ad];
    end
    if (st) o.rbm = last_rbm;
    else    last_rbm = o.rbm;
    op_q.push_back(o);
    cpu_start = 1'b1;
    cpu_store = st;
    cpu_addr  = base;
    cpu_wbm   = wbm;
    tick();
    cpu_start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (op_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    if (op_q.size() != 0) begin
      chk("done_timeout", 0, 1);
      op_q.delete();
      acc_q.delete();
    end
    tick();
  endtask

  task automatic set_aud(input int m);
    aud_mode = m;
    repeat (3) tick();
  endtask

  logic [BMW-1:0] w;
  logic [DW-1:0]  v;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      tbmem[i] = v;
      refm[i]  = v;
    end
    for (int i = 0; i < N; i++) begin
      tbmem[16'h0200 + i] = 16'h00A0 + 16'(i);
      refm[16'h0200 + i]  = 16'h00A0 + 16'(i);
    end

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_gnt", aud_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", aud_rvalid, 0);
    chk("rst_rbm", cpu_rbm, 0);
    tick();

    // Store, no audio
    for (int i = 0; i < N; i++) w[i*DW +: DW] = 16'h1000 + 16'(i);
    issue(1'b1, 16'h0100, w);
    wait_done();

    // Load, no audio; then a store must leave cpu_rbm alone
    issue(1'b0, 16'h0200, '0);
    wait_done();
    for (int i = 0; i < N; i++) w[i*DW +: DW] = 16'($urandom);
    issue(1'b1, 16'h0900, w);
    wait_done();

    // Address wrap
    issue(1'b0, 16'hFFFE, '0);
    wait_done();

    // Contention: audio held high through a load
    set_aud(1);
    issue(1'b0, 16'h0300, '0);
    wait_done();
    set_aud(0);

    // Reset at beat 3 of a load
    issue(1'b0, 16'h0400, '0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    op_q.delete();
    acc_q.delete();
    aud_q.delete();
    last_rbm = '0;
    @(negedge clk);
    chk("abort_rbm", cpu_rbm, 0);
    chk("abort_stall", cpu_stall, 0);
    chk("abort_done", cpu_done, 0);
    repeat (12) tick();
    issue(1'b0, 16'h0200, '0);
    wait_done();

    // Second cpu_start during BURST is ignored
    issue(1'b0, 16'h0500, '0);
    tick();
    cpu_start = 1'b1;
    cpu_store = 1'b1;
    cpu_addr  = 16'h0600;
    tick();
    cpu_start = 1'b0;
    wait_done();
    repeat (20) tick();

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      set_aud($urandom_range(0, 1) * 2);
      for (int i = 0; i < N; i++) w[i*DW +: DW] = 16'($urandom);
      issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hBFF0)), w);
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end
    set_aud(0);
    repeat (5) tick();
    chk("aud_drained", aud_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
